// File: rtl/msx_reset_sequencer.sv
// Central reset scheduler: merges PLL lock, OSD, button and mount requests into clean hard/soft reset pulses.
// Optional macro RESET_SEQ_DRAIN_EN: mount-triggered hard resets wait for the virtual SD card to go idle.
module msx_reset_sequencer #(
  parameter int unsigned LOCK_SETTLE   = 4096,
  parameter int unsigned HARD_CYCLES   = 21477,
  parameter int unsigned SOFT_CYCLES   = 2148,
  parameter int unsigned DRAIN_TIMEOUT = 65535
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       osd_hard_req,
  input  logic       osd_soft_req,
  input  logic       button_req,
  input  logic [1:0] img_mounted,
  input  logic       mount_reset_en,
  input  logic       sd_busy,
  output logic       hard_reset_o,
  output logic       soft_reset_o,
  output logic       boot_done_o,
  output logic [2:0] state_o
);

  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_SETTLE - 1);
  localparam logic [CNT_W-1:0] HARD_LAST   = CNT_W'(HARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_HARD  = 3'd1,
    ST_RUN   = 3'd2,
`ifdef RESET_SEQ_DRAIN_EN
    ST_DRAIN = 3'd3,
`endif
    ST_SOFT  = 3'd4
  } state_t;

`ifdef RESET_SEQ_DRAIN_EN
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam state_t MOUNT_DEST = ST_DRAIN;
`else
  localparam state_t MOUNT_DEST = ST_HARD;
  logic unused_sd_busy;
  assign unused_sd_busy = sd_busy;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;

  logic       lock_p0, lock_p1;
  logic       osd_hard_p0, osd_hard_p1;
  logic       osd_soft_p0, osd_soft_p1;
  logic       button_p0, button_p1;
  logic [1:0] img_p0, img_p1;

  logic lock_ok, hard_ev, soft_ev, mount_ev;

  // Stage p0: input capture / first synchronizer flop; stage p1: previous sample for edge detection
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lock_p0     <= 1'b0;
      lock_p1     <= 1'b0;
      osd_hard_p0 <= 1'b0;
      osd_hard_p1 <= 1'b0;
      osd_soft_p0 <= 1'b0;
      osd_soft_p1 <= 1'b0;
      button_p0   <= 1'b0;
      button_p1   <= 1'b0;
      img_p0      <= 2'b00;
      img_p1      <= 2'b00;
    end else begin
      lock_p0     <= pll_locked;
      lock_p1     <= lock_p0;
      osd_hard_p0 <= osd_hard_req;
      osd_hard_p1 <= osd_hard_p0;
      osd_soft_p0 <= osd_soft_req;
      osd_soft_p1 <= osd_soft_p0;
      button_p0   <= button_req;
      button_p1   <= button_p0;
      img_p0      <= img_mounted;
      img_p1      <= img_p0;
    end
  end

  assign lock_ok  = lock_p1;
  assign hard_ev  = (osd_hard_p0 & ~osd_hard_p1) | (button_p0 & ~button_p1);
  assign soft_ev  = osd_soft_p0 & ~osd_soft_p1;
  assign mount_ev = (|(img_p0 & ~img_p1)) & mount_reset_en;
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

  // Next-state: lock loss overrides everything, then the per-state priority order
  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    if (state != ST_INIT && !lock_ok) begin
      state_n = ST_INIT;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (!lock_ok) begin
            cnt_n = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end
        end
        ST_HARD: begin
          if (hard_ev || mount_ev) begin
            cnt_n = '0;
          end else if (cnt == HARD_LAST) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end
        end
        ST_RUN: begin
          cnt_n = '0;
          if (hard_ev)       state_n = ST_HARD;
          else if (mount_ev) state_n = MOUNT_DEST;
          else if (soft_ev)  state_n = ST_SOFT;
        end
`ifdef RESET_SEQ_DRAIN_EN
        ST_DRAIN: begin
          if (hard_ev || !sd_busy || cnt == DRAIN_LAST) begin
            state_n = ST_HARD;
            cnt_n   = '0;
          end
        end
`endif
        ST_SOFT: begin
          if (hard_ev) begin
            state_n = ST_HARD;
            cnt_n   = '0;
          end else if (mount_ev) begin
            state_n = MOUNT_DEST;
            cnt_n   = '0;
          end else if (soft_ev) begin
            cnt_n = '0;
          end else if (cnt == SOFT_LAST) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_INIT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hard_reset_o <= 1'b1;
      soft_reset_o <= 1'b0;
      boot_done_o  <= 1'b0;
    end else begin
      hard_reset_o <= (state_n == ST_INIT) || (state_n == ST_HARD);
      soft_reset_o <= (state_n == ST_SOFT);
      if (state == ST_INIT && state_n == ST_RUN) boot_done_o <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: doc/msx_reset_sequencer.md
# msx_reset_sequencer

Central reset scheduler for the MSX1 core, clocked on `clk_sys` (21.477 MHz). It merges the following sources into two clean, minimum-width reset outputs that drive the core's `reset` and `soft_reset_osd` inputs:
- PLL lock
- OSD hard and soft reset toggles
- the front-panel button
- the SD image-mount reset

Mount-triggered hard resets can be held off until the virtual SD card has gone idle, so an in-flight sector transfer is never cut.

## Interface
Parameters:
- `LOCK_SETTLE`, default 4096: cycles `pll_locked` must stay high before leaving INIT.
- `HARD_CYCLES`, default 21477: hard-reset pulse width in cycles (1 ms).
- `SOFT_CYCLES`, default 2148: soft-reset pulse width in cycles (100 µs).
- `DRAIN_TIMEOUT`, default 65535: maximum cycles spent waiting for `sd_busy` to drop.

Ports:
- `clk_sys` in, 1: system clock.
- `reset` in, 1: asynchronous, active-high reset. Forces INIT.
- `pll_locked` in, 1: PLL lock, asynchronous. Passes through a 2-FF synchronizer.
- `osd_hard_req` in, 1: OSD hard-reset toggle (`status[0]`). Level input; acts on rising edge.
- `osd_soft_req` in, 1: OSD soft-reset toggle (`status[1]`). Rising edge.
- `button_req` in, 1: board button (`buttons[1]`). Rising edge; treated as a hard request.
- `img_mounted` in, 2: mount strobes. Rising edge of either bit is a mount event.
- `mount_reset_en` in, 1: "Hard reset after Mount" option (`status[14]`).
- `sd_busy` in, 1: virtual SD transfer active.
- `hard_reset_o` out, 1: hard reset to the core.
- `soft_reset_o` out, 1: soft reset to the core.
- `boot_done_o` out, 1: set on the first INIT→RUN transition; sticky until `reset`.
- `state_o` out, 3: current state code, for debug.

## Operation
States and codes: INIT=0, HARD=1, RUN=2, DRAIN=3, SOFT=4.

- Edge detection:
  - Each request input is registered once.
  - An event is `in & ~in_q`, evaluated every cycle, so a held level produces exactly one event.
  - A mount event is counted only when `mount_reset_en=1` in the same cycle.
- INIT:
  - `hard_reset_o=1`, `soft_reset_o=0`.
  - The settle counter increments while the synchronized lock is 1 and clears to 0 whenever it is 0.
  - On reaching `LOCK_SETTLE-1`: go to RUN and set `boot_done_o`.
- HARD:
  - `hard_reset_o=1`; the counter runs 0..`HARD_CYCLES-1`, then go to RUN.
  - Any new hard, button or mount event restarts the counter at 0.
  - Soft events are ignored.
- RUN: both resets 0. Transitions, in priority order:
  - lock loss → INIT
  - OSD hard or button event → HARD
  - mount event → DRAIN
  - soft event → SOFT
- DRAIN:
  - Resets stay 0.
  - Exit to HARD when `sd_busy=0` or the drain counter reaches `DRAIN_TIMEOUT-1`.
  - An OSD hard or button event exits to HARD immediately.
  - Soft events are dropped.
- SOFT:
  - `soft_reset_o=1` for `SOFT_CYCLES` cycles, then go to RUN.
  - A hard or button event aborts to HARD; `soft_reset_o` drops in the same cycle `hard_reset_o` rises.
  - A mount event aborts to DRAIN.
  - A further soft event restarts the counter.
- Lock loss, from any state: go to INIT, clear all counters, and raise `hard_reset_o`. `boot_done_o` is unaffected.
- Simultaneous events resolve with the RUN priority order. Only one transition happens per cycle.
- Counters are 17 bits wide, saturate at their terminal value, and are cleared on every state entry.
- `hard_reset_o` and `soft_reset_o` are never both 1.

## Timing
- Values held while `reset` is asserted:
  - `hard_reset_o=1`, `soft_reset_o=0`, `boot_done_o=0`, `state_o=0`.
  - All edge registers are 0, so a request input that is high at reset release produces an event on the first cycle.
- All outputs are registered.
- Request latency: if a rising input is sampled at edge k, the state changes at edge k+1 and the output changes after edge k+1 (2 cycles).
- Lock-loss latency: `hard_reset_o` rises at most 3 edges after `pll_locked` falls.
- Pulse widths:
  - `hard_reset_o` stays high exactly `HARD_CYCLES` cycles after the last restart.
  - `soft_reset_o` stays high exactly `SOFT_CYCLES` cycles.
- DRAIN exit: `sd_busy` falling at edge k gives `hard_reset_o`=1 after edge k+1.
- Asynchronous `reset` asserted mid-pulse forces INIT immediately. On release, INIT runs the full `LOCK_SETTLE` again.

## Configuration
- `RESET_SEQ_DRAIN_EN`:
  - Defined: DRAIN is implemented as described.
  - Undefined: a mount event goes RUN→HARD directly, `sd_busy` is unused, DRAIN and its counter are removed, and state code 3 is never produced.

## Test plan
Bench parameters: `LOCK_SETTLE=16`, `HARD_CYCLES=8`, `SOFT_CYCLES=4`, `DRAIN_TIMEOUT=32`.

- Power-up: `pll_locked` high from release → `hard_reset_o=1` throughout INIT. RUN is entered 16 cycles after lock reaches the synchronizer; `boot_done_o` rises in the same cycle as RUN is entered. A lock glitch at cycle 10 restarts the count.
- OSD soft pulse in RUN:
  - `soft_reset_o` rises 2 cycles later and stays high 4 cycles.
  - Holding `osd_soft_req` high produces no second pulse.
- Hard in SOFT: a button rise at soft cycle 2 → `soft_reset_o` drops and `hard_reset_o` rises in the same cycle; the hard pulse is 8 cycles.
- Mount with `mount_reset_en=1` and `sd_busy=1` (DRAIN enabled):
  - No reset while busy.
  - Dropping `sd_busy` at edge k gives `hard_reset_o` after edge k+1.
  - If `sd_busy` stays high, `hard_reset_o` asserts after the 32-cycle timeout.
  - With `mount_reset_en=0`, nothing happens.
- Lock loss mid-HARD, and async `reset` mid-SOFT: the state goes to INIT, the outputs return to their reset values within the stated latency, and `boot_done_o` is retained on lock loss but cleared by `reset`.
